param_reg_file: RTL

- Parametrised successor to the 32x32, two-read/one-write RISC register file.
- Generalised in data width, register count and read-port count.
- Adds:
  - synchronous clear;
  - optional hardwired zero register;
  - write-to-read bypass;
  - selectable combinational or registered read;
  - per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (read ports and reserve port) and writeback (write port) of the RISC datapath.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/param_reg_file.sv | 94 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg -- shared constants and helpers for the parametrised register file.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default geometry (32 x 32-bit, 2 read ports)
//   rf_slice(port, width)             : LSB offset of a port inside a packed multi-port bus
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  // Packed port buses place port i at bits [i*width +: width].
  function automatic int rf_slice(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard -- per-register busy bits used by decode for hazard detection.
// Ports:
//   clk, rst           : clock, synchronous active-high reset (clears every busy bit)
//   wr_en/wr_addr      : writeback completes a register, clearing its busy bit
//   rsv_en/rsv_addr    : decode issues a producer, setting the busy bit
//   rd_addr (packed)   : one address per read port
//   rd_busy            : busy flag of the register addressed by each read port
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Reserve is applied after the write clear: when both hit the same register
  // a new producer has been issued, so the register must stay pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic              port_busy;

      assign addr = rd_addr[rf_slice(gi, ADDR_W) +: ADDR_W];

      always_comb begin
        port_busy = busy_q[addr];
        // A completing write releases the consumer this cycle, unless the
        // same register is being re-reserved right now.
        if (BYPASS != 0 && wr_en && (wr_addr == addr) && !(rsv_en && (rsv_addr == addr)))
          port_busy = 1'b0;
        if (ZERO_REG != 0 && addr == '0)
          port_busy = 1'b0;
      end

      assign rd_busy[gi] = port_busy;
    end
  endgenerate

endmodule

// File: rtl/param_reg_file.sv
// param_reg_file -- parametrised multi-read-port register file with busy scoreboard.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears data, busy, read regs)
//   rd_addr / rd_data   : NUM_RD packed read ports (addresses / data)
//   rd_busy             : busy flag of each addressed register
//   wr_en/wr_addr/wr_data : writeback port
//   rsv_en/rsv_addr     : reserve port (marks a destination pending)
// Parameters: ZERO_REG hardwires r0, BYPASS forwards same-cycle writes to reads,
// READ_LAT selects combinational (0) or registered (1) read data.
module param_reg_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int NREG = 1 << ADDR_W;

  // Whole-array synchronous clear keeps this in registers rather than RAM.
  logic [DATA_W-1:0] mem_q [NREG];
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) mem_q[k] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] comb_data;

      assign addr = rd_addr[rf_slice(gi, ADDR_W) +: ADDR_W];

      always_comb begin
        comb_data = mem_q[addr];
        if (BYPASS != 0 && wr_en && (wr_addr == addr))
          comb_data = wr_data;
        if (ZERO_REG != 0 && addr == '0)
          comb_data = '0;
      end

      if (READ_LAT != 0) begin : g_reg
        // Captures exactly what the combinational path shows this cycle.
        logic [DATA_W-1:0] data_q;
        always_ff @(posedge clk) begin
          if (rst) data_q <= '0;
          else     data_q <= comb_data;
        end
        assign rd_data[rf_slice(gi, DATA_W) +: DATA_W] = data_q;
      end else begin : g_comb
        assign rd_data[rf_slice(gi, DATA_W) +: DATA_W] = comb_data;
      end
    end
  endgenerate

endmodule
